// File: rtl/sakebi_pkg.sv
// Shared constants and types for the sakebi FIFO read-side prefetch logic.
package sakebi_pkg;

  localparam int unsigned SAKEBI_RD_BUF_DEPTH = 3;
  localparam int unsigned SAKEBI_RD_PTR_W     = $clog2(SAKEBI_RD_BUF_DEPTH);
  localparam int unsigned SAKEBI_RD_CNT_W     = $clog2(SAKEBI_RD_BUF_DEPTH + 1);

  typedef logic [SAKEBI_RD_PTR_W-1:0] sakebi_ptr_t;
  typedef logic [SAKEBI_RD_CNT_W-1:0] sakebi_cnt_t;
  // One bit wider than the count so count + inflight never overflows.
  typedef logic [SAKEBI_RD_CNT_W:0]   sakebi_occ_t;

  function automatic sakebi_ptr_t sakebi_ptr_inc(input sakebi_ptr_t ptr);
    return (ptr == sakebi_ptr_t'(SAKEBI_RD_BUF_DEPTH - 1)) ? '0 : ptr + sakebi_ptr_t'(1);
  endfunction

endpackage

// File: rtl/sakebi_prefetch_buf.sv
// Small circular prefetch buffer: push/pop, occupancy count and head data.
module sakebi_prefetch_buf
  import sakebi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output sakebi_cnt_t           o_count,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_head_data
);

  logic [DATA_WIDTH-1:0] mem_q [SAKEBI_RD_BUF_DEPTH];
  sakebi_ptr_t           wr_ptr_q, wr_ptr_d;
  sakebi_ptr_t           rd_ptr_q, rd_ptr_d;
  sakebi_cnt_t           count_q, count_d;
  logic                  pop_ok;

  assign pop_ok = i_pop & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) begin
      wr_ptr_d = sakebi_ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = sakebi_ptr_inc(rd_ptr_q);
    end
    unique case ({i_push, pop_ok})
      2'b10:   count_d = count_q + sakebi_cnt_t'(1);
      2'b01:   count_d = count_q - sakebi_cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entries are cleared on reset so the head reads 0 until the first push.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < SAKEBI_RD_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (i_push) begin
      mem_q[wr_ptr_q] <= i_push_data;
    end
  end

  assign o_count     = count_q;
  assign o_valid     = (count_q != '0);
  assign o_head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/sakebi_fifo_reader.sv
// Drains the async FIFO read port into a valid/ready byte stream via a prefetch buffer.
// Define SAKEBI_RD_TLAST_EN to generate o_last every FRAME_LEN beats.
module sakebi_fifo_reader
  import sakebi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FRAME_LEN  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_fifo_ready,
  output logic                  o_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);

  logic        run_q;
  logic        inflight_q;
  sakebi_cnt_t count;
  sakebi_occ_t occupancy;
  logic        pop;

  // Reads still in flight count against capacity, so a stall never overflows.
  assign occupancy    = sakebi_occ_t'(count) + sakebi_occ_t'(inflight_q);
  assign o_fifo_rd_en = run_q & i_fifo_ready & (occupancy < sakebi_occ_t'(SAKEBI_RD_BUF_DEPTH));
  assign pop          = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= o_fifo_rd_en;
    end
  end

  sakebi_prefetch_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_push      (inflight_q),
    .i_push_data (i_fifo_data),
    .i_pop       (pop),
    .o_count     (count),
    .o_valid     (o_valid),
    .o_head_data (o_data)
  );

`ifdef SAKEBI_RD_TLAST_EN
  localparam int unsigned BeatW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BeatW-1:0] BeatMax = BeatW'(FRAME_LEN - 1);

  logic [BeatW-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (pop) begin
      beat_d = (beat_q == BeatMax) ? '0 : beat_q + BeatW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign o_last = o_valid & (beat_q == BeatMax);
`else
  assign o_last = 1'b0;
`endif

endmodule

// File: tb/tb_sakebi_fifo_reader.sv
// Randomized bench for sakebi_fifo_reader with a queue-level FIFO model and stream scoreboard.
module tb_sakebi_fifo_reader;

  localparam int unsigned DW  = 8;
  localparam int unsigned FL  = 4;
`ifdef SAKEBI_RD_TLAST_EN
  localparam bit TlastEn = 1'b1;
`else
  localparam bit TlastEn = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_ready = 1'b0;
  logic          fifo_en = 1'b0;
  logic          i_fifo_ready;
  logic [DW-1:0] i_fifo_data = '0;
  logic          o_fifo_rd_en, o_valid, o_last;
  logic [DW-1:0] o_data;
  logic          rd_en1, o_valid1, o_last1;
  logic [DW-1:0] o_data1;

  always #5 i_clk = ~i_clk;

  // FIFO model: contents in mem[rd_idx..wr_idx-1], registered read data.
  logic [DW-1:0] mem [4096];
  int wr_idx = 0;
  int rd_idx = 0;
  int underflows = 0;

  assign i_fifo_ready = fifo_en && (rd_idx != wr_idx);

  always @(posedge i_clk) begin
    if (o_fifo_rd_en) begin
      if (rd_idx == wr_idx) begin
        underflows <= underflows + 1;
      end else begin
        i_fifo_data <= mem[rd_idx[11:0]];
        rd_idx      <= rd_idx + 1;
      end
    end
  end

  sakebi_fifo_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_fifo_ready(i_fifo_ready), .o_fifo_rd_en(o_fifo_rd_en),
    .i_fifo_data(i_fifo_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_last(o_last)
  );

  sakebi_fifo_reader #(.DATA_WIDTH(DW), .FRAME_LEN(1)) dut1 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_fifo_ready(i_fifo_ready), .o_fifo_rd_en(rd_en1),
    .i_fifo_data(i_fifo_data), .o_valid(o_valid1), .i_ready(i_ready), .o_data(o_data1),
    .o_last(o_last1)
  );

  // Stream model: reads performed since reset, beats accepted, reads that have landed.
  int vectors = 0;
  int errors = 0;
  int base = 0;
  int accepted = 0;
  int issued_prev = 0;
  int beat_no = 0;

  task automatic preload(input int n, input int first, input bit rnd);
    for (int i = 0; i < n; i++) begin
      mem[wr_idx[11:0]] = rnd ? DW'($urandom) : DW'(first + i);
      wr_idx++;
    end
  endtask

  // One-cycle reset pulse; leaves the bench at the negedge after release.
  task automatic reset_dut();
    @(negedge i_clk);
    i_rstn  = 1'b0;
    i_ready = 1'b0;
    @(negedge i_clk);
    i_rstn      = 1'b1;
    base        = rd_idx;
    accepted    = 0;
    issued_prev = 0;
    beat_no     = 0;
  endtask

  task automatic tick(input bit rdy, input bit fen, output bit rden_seen, output bit beat,
                      output bit last_seen);
    int            issued;
    bit            exp_valid, exp_rden, exp_last;
    logic [DW-1:0] exp_data;
    @(negedge i_clk);
    issued    = rd_idx - base;
    exp_valid = (issued_prev > accepted);
    exp_rden  = i_fifo_ready && ((issued - accepted) < 3);
    rden_seen = o_fifo_rd_en;
    beat      = 1'b0;
    last_seen = 1'b0;
    vectors += 4;
    if (o_valid !== exp_valid) begin
      errors++; $display("FAIL valid: got %b expected %b at %0t", o_valid, exp_valid, $time);
    end
    if (o_fifo_rd_en !== exp_rden) begin
      errors++; $display("FAIL rd_en: got %b expected %b at %0t", o_fifo_rd_en, exp_rden, $time);
    end
    if (rd_en1 !== exp_rden) begin
      errors++; $display("FAIL rd_en1: got %b expected %b at %0t", rd_en1, exp_rden, $time);
    end
    if (o_valid1 !== exp_valid) begin
      errors++; $display("FAIL valid1: got %b expected %b at %0t", o_valid1, exp_valid, $time);
    end
    i_ready = rdy;
    if (exp_valid) begin
      exp_data = mem[12'(base + accepted)];
      exp_last = TlastEn && ((beat_no % int'(FL)) == int'(FL) - 1);
      vectors += 4;
      if (o_data !== exp_data) begin
        errors++; $display("FAIL data: got %h expected %h at %0t", o_data, exp_data, $time);
      end
      if (o_data1 !== exp_data) begin
        errors++; $display("FAIL data1: got %h expected %h at %0t", o_data1, exp_data, $time);
      end
      if (o_last !== exp_last) begin
        errors++; $display("FAIL last: got %b expected %b beat %0d", o_last, exp_last, beat_no);
      end
      if (o_last1 !== TlastEn) begin
        errors++; $display("FAIL last1: got %b expected %b beat %0d", o_last1, TlastEn, beat_no);
      end
      if (rdy) begin
        beat      = 1'b1;
        last_seen = o_last;
        accepted++;
        beat_no++;
      end
    end else begin
      vectors += 2;
      if (o_last !== 1'b0) begin
        errors++; $display("FAIL idle_last: got %b expected 0 at %0t", o_last, $time);
      end
      if (o_last1 !== 1'b0) begin
        errors++; $display("FAIL idle_last1: got %b expected 0 at %0t", o_last1, $time);
      end
    end
    issued_prev = issued;
    fifo_en     = fen;
  endtask

  task automatic test_reset();
    fifo_en = 1'b0;
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      vectors += 4;
      if (o_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b expected 0", o_fifo_rd_en); end
      if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
      if (o_data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 00", o_data); end
      if (o_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", o_last); end
      @(negedge i_clk);
    end
  endtask

  task automatic test_stream();
    bit r, b, l;
    int first_rd = -1, first_beat = -1, last_beat = -1;
    reset_dut();
    preload(16, 1, 1'b0);
    fifo_en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick(1'b1, 1'b1, r, b, l);
      if (r && first_rd < 0) first_rd = c;
      if (b && first_beat < 0) first_beat = c;
      if (b) last_beat = c;
    end
    vectors += 3;
    if (accepted !== 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", accepted); end
    if (first_beat - first_rd !== 2) begin
      errors++; $display("FAIL first_latency: got %0d expected 2", first_beat - first_rd);
    end
    if (last_beat - first_beat !== 15) begin
      errors++; $display("FAIL throughput: got %0d expected 15", last_beat - first_beat);
    end
  endtask

  task automatic test_stall();
    bit r, b, l;
    int pulses = 0;
    reset_dut();
    preload(16, 1, 1'b0);
    fifo_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 1'b1, r, b, l);
      if (r) pulses++;
    end
    vectors += 2;
    if (pulses !== 3) begin errors++; $display("FAIL stall_reads: got %0d expected 3", pulses); end
    if (o_data !== 8'h01) begin errors++; $display("FAIL stall_head: got %h expected 01", o_data); end
    for (int c = 0; c < 25; c++) tick(1'b1, 1'b1, r, b, l);
    vectors++;
    if (accepted !== 16) begin errors++; $display("FAIL stall_count: got %0d expected 16", accepted); end
  endtask

  task automatic test_random();
    bit r, b, l;
    int pushed = 0, guard = 0;
    reset_dut();
    while (accepted < 1000 && guard < 20000) begin
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), r, b, l);
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        preload(1, 0, 1'b1);
        pushed++;
      end
      guard++;
    end
    vectors++;
    if (accepted !== 1000) begin errors++; $display("FAIL random_count: got %0d expected 1000", accepted); end
  endtask

  task automatic test_tlast();
    bit r, b, l;
    int lasts = 0, wrong = 0;
    reset_dut();
    preload(12, 8'h40, 1'b0);
    fifo_en = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick(1'b1, 1'b1, r, b, l);
      if (b && l) begin
        lasts++;
        if ((accepted % 4) != 0) wrong++;
      end
    end
    vectors += 2;
    if (lasts !== (TlastEn ? 3 : 0)) begin
      errors++; $display("FAIL tlast_count: got %0d expected %0d", lasts, TlastEn ? 3 : 0);
    end
    if (wrong !== 0) begin errors++; $display("FAIL tlast_pos: got %0d expected 0", wrong); end
  endtask

  task automatic test_mid_reset();
    bit r, b, l;
    int remaining;
    reset_dut();
    preload(16, 8'h80, 1'b0);
    fifo_en = 1'b1;
    for (int c = 0; c < 8; c++) tick(1'b0, 1'b1, r, b, l);
    vectors++;
    if (o_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", o_valid); end
    reset_dut();
    vectors += 3;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", o_valid); end
    if (o_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_en: got %b expected 0", o_fifo_rd_en); end
    if (o_data !== '0) begin errors++; $display("FAIL mid_rst_data: got %h expected 00", o_data); end
    remaining = wr_idx - base;
    for (int c = 0; c < 30; c++) tick(1'b1, 1'b1, r, b, l);
    vectors++;
    if (accepted !== remaining) begin
      errors++; $display("FAIL resume_count: got %0d expected %0d", accepted, remaining);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_random();
    test_tlast();
    test_mid_reset();
    vectors++;
    if (underflows !== 0) begin errors++; $display("FAIL underflow: got %0d expected 0", underflows); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sakebi_fifo_reader.md
# sakebi_fifo_reader

Drains the read side of the team's async FIFO and presents its contents as a valid/ready byte stream in the read clock domain. It hides the FIFO's one-cycle registered read latency behind a 3-entry prefetch buffer, so the stream sustains one beat per cycle. With the optional feature compiled in, it also marks frame boundaries. It sits between the async FIFO read port and the downstream frame/serializer logic.

## Interface
- DATA_WIDTH, 8, width of FIFO word and stream data
- FRAME_LEN, 64, beats per frame for o_last generation; integer ≥1
- i_clk  in  1  clock; same clock as the FIFO read port (i_rd_clk)
- i_rstn  in  1  reset: one clock; reset is synchronous and active-low
- i_fifo_ready  in  1  FIFO not-empty flag (FIFO o_rd_ready)
- o_fifo_rd_en  out  1  read request to FIFO (FIFO i_rd_en)
- i_fifo_data  in  DATA_WIDTH  FIFO read data (FIFO o_rd_data); valid one cycle after an accepted read
- o_valid  out  1  stream beat available
- i_ready  in  1  downstream accepts beat
- o_data  out  DATA_WIDTH  stream data
- o_last  out  1  final beat of frame; constant 0 without SAKEBI_RD_TLAST_EN

## Operation
- State: 3-entry circular buffer (wr ptr, rd ptr, count 0..3), r_inflight flag, r_run flag, and a beat counter when the macro is enabled.
- r_run is 0 in reset and 1 on the first cycle after reset. o_fifo_rd_en = r_run & i_fifo_ready & (count + r_inflight < 3). It depends on registered state and i_fifo_ready only. It never depends on i_ready.
- r_inflight <= o_fifo_rd_en every cycle.
- When r_inflight=1, i_fifo_data is written to the buffer at the wr ptr that cycle.
- Push and pop in the same cycle leave count unchanged. Pointers wrap 2→0.
- o_valid = (count != 0). o_data/o_last are taken from the rd-ptr entry. A pop occurs on o_valid & i_ready.
- o_data is undefined-but-stable while o_valid=0 and must not change while o_valid=1 and i_ready=0. Same for o_last.
- Empty FIFO: no reads are issued. A stalled downstream stops reads once count + inflight = 3, so there is no overflow and no loss.
- Ordering: stream order equals FIFO order, with no duplicates or drops.

## Timing
- Reset values: o_fifo_rd_en=0, o_valid=0, o_data=0, o_last=0, count=0, r_inflight=0, beat counter=0.
- Latency: the first beat after the FIFO goes non-empty needs 1 cycle (r_run/issue) for the read, 1 cycle for the data to land in the FIFO output register, and 1 cycle to write the buffer. o_valid is high 2 cycles after o_fifo_rd_en first rises.
- Throughput: with i_fifo_ready and i_ready held high, it sustains 1 beat/cycle after fill.
- Backpressure: after i_ready falls, at most 3 beats are held (buffered plus in flight). o_fifo_rd_en falls in the same cycle count + inflight reaches 3.
- Reset mid-operation: buffered and in-flight beats are discarded. i_rstn must be asserted together with the FIFO's i_rd_rstn.

## Configuration
- SAKEBI_RD_TLAST_EN defined:
  - A beat counter, $clog2(FRAME_LEN) bits (min 1), increments on each pop and wraps to 0 after the pop where counter = FRAME_LEN-1.
  - o_last = o_valid & (counter == FRAME_LEN-1).
  - With FRAME_LEN=1, o_last=o_valid.
- Not defined: the counter is absent and o_last is tied 0.

## Structure
- Shared package sakebi_pkg: localparam SAKEBI_RD_BUF_DEPTH=3 and the pointer/count width derived from it.
- One sub-module, sakebi_prefetch_buf: 3-entry circular buffer with push/pop, count, and head data output. The top holds r_run, r_inflight, the issue logic and the beat counter.

## Test plan
- Reset, FIFO empty (i_fifo_ready=0) for 10 cycles → o_fifo_rd_en=0, o_valid=0, o_data=0, o_last=0 throughout.
- Preload FIFO with 0x01..0x10, i_ready=1 → 16 beats 0x01..0x10 on consecutive cycles; first o_valid 2 cycles after first o_fifo_rd_en.
- Same preload, i_ready=0 for 20 cycles, then 1 → exactly 3 o_fifo_rd_en pulses during the stall; o_data held at 0x01; then all 16 beats delivered in order.
- Random i_ready (50%) and random i_fifo_ready gaps, 1000 bytes → scoreboard shows no loss, duplication or reorder; o_data stable while stalled.
- SAKEBI_RD_TLAST_EN, FRAME_LEN=4, 12 bytes → o_last on beats 4, 8, 12 only. Repeat with FRAME_LEN=1 → o_last on every beat.
- i_rstn low for 1 cycle with 3 beats buffered and i_ready=0 → next cycle o_valid=0, count=0; traffic resumes cleanly after reset.
